// File: rtl/partial_acc_sched.sv
// partial_acc_sched: sums N_PART signed partial LUT results into one output
// sample, presenting the partial index on part_sel and holding the finished
// sum on acc_out until the consumer takes it with out_ready.
//
// Build option: define PARTIAL_ACC_SAT_EN to saturate each add at the signed
// W-bit limits; left undefined, every add wraps modulo 2^W.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; acc_out keeps the last sum
// ACCUM | one add per edge, part_sel steps 0..N_PART-1
// HOLD  | out_valid high, acc_out frozen until out_ready

module partial_acc_sched #(
  parameter int N_PART = 8,
  parameter int W      = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic [$clog2(N_PART)-1:0] part_sel,
  input  logic signed [W-1:0]       part_data,
  output logic signed [W-1:0]       acc_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      overrun
);

  localparam int SW = $clog2(N_PART);
  localparam logic [SW-1:0] SEL_LAST = SW'(N_PART - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic signed [W-1:0]   acc_q, acc_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic signed [W-1:0]   add_res;

`ifdef PARTIAL_ACC_SAT_EN
  localparam logic signed [W-1:0] ACC_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] ACC_MIN = {1'b1, {(W-1){1'b0}}};

  logic signed [W:0] sum_ext;

  // One extra bit exposes overflow; clamp toward the sign of the true sum.
  always_comb begin
    sum_ext = {acc_q[W-1], acc_q} + {part_data[W-1], part_data};
    add_res = sum_ext[W-1:0];
    if (sum_ext[W] != sum_ext[W-1]) begin
      add_res = sum_ext[W] ? ACC_MIN : ACC_MAX;
    end
  end
`else
  // Plain W-bit add; the carry out is dropped so the result wraps.
  always_comb begin
    add_res = acc_q + part_data;
  end
`endif

  // Next-state and datapath decisions for the scheduler.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          acc_d   = '0;
          sel_d   = '0;
        end
      end

      S_ACCUM: begin
        acc_d = add_res;
        if (sel_q == SEL_LAST) begin
          // Index parks at 0 rather than running into unused codes.
          state_d = S_HOLD;
          valid_d = 1'b1;
          sel_d   = '0;
        end else begin
          sel_d = sel_q + SW'(1);
        end
        if (start) begin
          overrun_d = 1'b1;
        end
      end

      S_HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (start) begin
            // Same-edge handoff: the old sum leaves as the new one begins.
            state_d = S_ACCUM;
            acc_d   = '0;
            sel_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (start) begin
          overrun_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        sel_d   = '0;
      end
    endcase
  end

  // State registers; reset discards any sum in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      sel_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign part_sel  = sel_q;
  assign acc_out   = acc_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_partial_acc_sched.sv
// Self-checking bench for partial_acc_sched (N_PART=8 and N_PART=6 instances).
module tb_partial_acc_sched;

  localparam int W = 15;
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int MINV = -(1 << (W - 1));

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                start, out_ready, out_valid, busy, overrun;
  logic [2:0]          part_sel;
  logic signed [W-1:0] part_data, acc_out;

  logic                start_6, out_ready_6, out_valid_6, busy_6, overrun_6;
  logic [2:0]          part_sel_6;
  logic signed [W-1:0] part_data_6, acc_out_6;

  logic signed [W-1:0] tab  [8];
  logic signed [W-1:0] tab6 [8];

  logic signed [W-1:0] exp_q [$];
  logic signed [W-1:0] last_exp;
  int checks = 0;
  int errors = 0;

  partial_acc_sched #(.N_PART(8), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .part_sel(part_sel),
    .part_data(part_data), .acc_out(acc_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .overrun(overrun)
  );

  partial_acc_sched #(.N_PART(6), .W(W)) dut6 (
    .clk(clk), .rst(rst), .start(start_6), .part_sel(part_sel_6),
    .part_data(part_data_6), .acc_out(acc_out_6), .out_valid(out_valid_6),
    .out_ready(out_ready_6), .busy(busy_6), .overrun(overrun_6)
  );

  // Upstream LUT mux: data follows part_sel in the same cycle.
  always_comb part_data   = tab[part_sel];
  always_comb part_data_6 = tab6[part_sel_6];

  // Reference sum, step by step in integer arithmetic.
  function automatic logic signed [W-1:0] model_sum(input int n, input logic signed [W-1:0] t [8]);
    int acc;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      acc = acc + int'(t[i]);
`ifdef PARTIAL_ACC_SAT_EN
      if (acc > MAXV) acc = MAXV;
      else if (acc < MINV) acc = MINV;
`else
      acc = acc & ((1 << W) - 1);
      if (acc > MAXV) acc = acc - (1 << W);
`endif
    end
    return W'(acc);
  endfunction

  // Drives one sample through dut from a negedge; ends in HOLD.
  // ovr_at > 0 pulses start in ACCUM before add edge ovr_at.
  task automatic run_sample(input string tag, input int ovr_at, input bit handoff);
    exp_q.push_back(model_sum(8, tab));
    start = 1'b1;
    if (handoff) out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (busy !== 1'b1 || part_sel !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_start: busy=%b part_sel=%0d out_valid=%b, expected 1 0 0", tag, busy, part_sel, out_valid);
    end
    for (int i = 1; i <= 8; i++) begin
      if (i == ovr_at) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (i == ovr_at) begin
        checks++;
        if (overrun !== 1'b1) begin
          errors++;
          $display("FAIL %s_overrun: overrun=%b expected 1", tag, overrun);
        end
      end
      if (i < 8) begin
        checks++;
        if (part_sel !== 3'(i) || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s_step%0d: part_sel=%0d out_valid=%b, expected %0d 0", tag, i, part_sel, out_valid, i);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b1 || part_sel !== 3'd0) begin
          errors++;
          $display("FAIL %s_latency: out_valid=%b part_sel=%0d, expected 1 0", tag, out_valid, part_sel);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s_sum: no expected value queued, acc_out=%0d", tag, acc_out);
        end else begin
          last_exp = exp_q.pop_front();
          if (acc_out !== last_exp) begin
            errors++;
            $display("FAIL %s_sum: acc_out=%0d expected %0d", tag, acc_out, last_exp);
          end
        end
      end
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: out_valid=%b busy=%b, expected 0 0", tag, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (acc_out !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || part_sel !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: acc=%0d valid=%b busy=%b ovr=%b sel=%0d, expected all 0",
               acc_out, out_valid, busy, overrun, part_sel);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 8; i++) tab[i] = W'(i + 1);
    run_sample("basic", 0, 1'b0);
    checks++;
    if (acc_out !== 15'sd36) begin
      errors++;
      $display("FAIL basic_36: acc_out=%0d expected 36", acc_out);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      tab[i] = W'(100 * i - 7);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || acc_out !== last_exp || busy !== 1'b1) begin
        errors++;
        $display("FAIL hold_stable%0d: valid=%b acc=%0d busy=%b, expected 1 %0d 1", i, out_valid, acc_out, busy, last_exp);
      end
    end
    release_out("hold");
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 8; i++) tab[i] = W'(3 * i - 11);
    run_sample("ovr", 3, 1'b0);
    // start in HOLD without out_ready: dropped, HOLD kept.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || acc_out !== last_exp || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_hold_start: valid=%b acc=%0d ovr=%b, expected 1 %0d 1", out_valid, acc_out, overrun, last_exp);
    end
    for (int i = 0; i < 8; i++) tab[i] = W'(-50 + 20 * i);
    run_sample("handoff", 0, 1'b1);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL handoff_overrun: overrun=%b expected 1", overrun);
    end
    release_out("handoff");
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 8; i++) tab[i] = 15'sd16383;
    run_sample("pos_ovf", 0, 1'b0);
    checks++;
`ifdef PARTIAL_ACC_SAT_EN
    if (acc_out !== 15'sd16383) begin
`else
    if (acc_out !== -15'sd8) begin
`endif
      errors++;
      $display("FAIL pos_ovf_const: acc_out=%0d", acc_out);
    end
    release_out("pos_ovf");
    for (int i = 0; i < 8; i++) tab[i] = -15'sd16384;
    run_sample("neg_ovf", 0, 1'b0);
    release_out("neg_ovf");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) tab[i] = W'(7 * i + 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (acc_out !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || part_sel !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset: acc=%0d valid=%b busy=%b ovr=%b sel=%0d, expected all 0",
               acc_out, out_valid, busy, overrun, part_sel);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_hold: out_valid=%b expected 0", out_valid);
    end
    rst = 1'b1;
    exp_q.delete();
    run_sample("after_rst", 0, 1'b0);
    release_out("after_rst");
  endtask

  task automatic test_n6();
    logic signed [W-1:0] e6;
    for (int i = 0; i < 8; i++) tab6[i] = W'(5 * i - 7);
    e6 = model_sum(6, tab6);
    start_6 = 1'b1;
    @(negedge clk);
    start_6 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      checks++;
      if (part_sel_6 > 3'd5) begin
        errors++;
        $display("FAIL n6_range%0d: part_sel=%0d exceeds 5", i, part_sel_6);
      end
      if (i < 6) begin
        checks++;
        if (part_sel_6 !== 3'(i) || out_valid_6 !== 1'b0) begin
          errors++;
          $display("FAIL n6_step%0d: part_sel=%0d valid=%b, expected %0d 0", i, part_sel_6, out_valid_6, i);
        end
      end else begin
        checks++;
        if (out_valid_6 !== 1'b1 || acc_out_6 !== e6 || part_sel_6 !== 3'd0) begin
          errors++;
          $display("FAIL n6_done: valid=%b acc=%0d sel=%0d, expected 1 %0d 0", out_valid_6, acc_out_6, part_sel_6, e6);
        end
      end
    end
    out_ready_6 = 1'b1;
    @(negedge clk);
    out_ready_6 = 1'b0;
    checks++;
    if (busy_6 !== 1'b0 || out_valid_6 !== 1'b0) begin
      errors++;
      $display("FAIL n6_release: busy=%b valid=%b, expected 0 0", busy_6, out_valid_6);
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    start_6 = 1'b0;
    out_ready_6 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tab[i] = '0;
      tab6[i] = '0;
    end
    #12;
    test_reset();
    test_basic();
    test_hold();
    test_overrun();
    test_saturate();
    test_reset_mid();
    test_n6();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
